// File: rtl/gate_lane_arbiter_pkg.sv
// Shared types for the single-arm lane arbiter: gate command encoding,
// arbiter FSM states and lane identifiers.
package gate_pkg;

  typedef enum logic [1:0] {
    DOWN       = 2'd0,
    UP_START   = 2'd1,
    UP         = 2'd2,
    DOWN_START = 2'd3
  } tal_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } arb_state_t;

  typedef enum logic {
    LANE_IN  = 1'b0,
    LANE_OUT = 1'b1
  } lane_t;

  function automatic tal_t tal_of(input arb_state_t s);
    case (s)
      OPENING: return UP_START;
      OPEN:    return UP;
      CLOSING: return DOWN_START;
      default: return DOWN;
    endcase
  endfunction

endpackage

// File: rtl/gate_lane_arbiter_if.sv
// Lane-side bundle: requests and car sensor in, gate command, grants and occupancy out.
interface gate_lane_arbiter_if #(
  parameter int CAPACITY = 8
);
  import gate_pkg::*;

  localparam int OCC_W = $clog2(CAPACITY + 1);

  logic             REQ_IN;
  logic             REQ_OUT;
  logic             C;
  tal_t             TAL;
  logic             GNT_IN;
  logic             GNT_OUT;
  logic [OCC_W-1:0] OCC;
  logic             FULL;
  logic             EMPTY;

  modport master (
    output REQ_IN, REQ_OUT, C,
    input  TAL, GNT_IN, GNT_OUT, OCC, FULL, EMPTY
  );

  modport slave (
    input  REQ_IN, REQ_OUT, C,
    output TAL, GNT_IN, GNT_OUT, OCC, FULL, EMPTY
  );

endinterface

// File: rtl/gate_lane_arbiter_occupancy_counter.sv
// Saturation-free occupancy counter; the arbiter's eligibility gating keeps it in range.
module occupancy_counter #(
  parameter int CAPACITY = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inc_i,
  input  logic                             dec_i,
  output logic [$clog2(CAPACITY+1)-1:0]    occ_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int OCC_W = $clog2(CAPACITY + 1);

  logic [OCC_W-1:0] occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      assert (!(inc_i && dec_i));
      assert (!(inc_i && occ_q == OCC_W'(CAPACITY)));
      assert (!(dec_i && occ_q == '0));
      if (inc_i)      occ_q <= occ_q + 1'b1;
      else if (dec_i) occ_q <= occ_q - 1'b1;
    end
  end

  assign occ_o   = occ_q;
  assign full_o  = (occ_q == OCC_W'(CAPACITY));
  assign empty_o = (occ_q == '0);

endmodule

// File: rtl/gate_lane_arbiter.sv
// Round-robin arbiter driving one barrier arm through timed open/close phases
// for a shared entry/exit lane, with occupancy tracking.
module gate_lane_arbiter
  import gate_pkg::*;
#(
  parameter int CAPACITY  = 8,
  parameter int OPEN_CYC  = 4,
  parameter int CLOSE_CYC = 4,
  parameter int TIMEOUT   = 16
) (
  input logic                clk,
  input logic                R,
  gate_lane_arbiter_if.slave bus
);

  localparam int OCC_W  = $clog2(CAPACITY + 1);
  localparam int TMAX_A = (OPEN_CYC > CLOSE_CYC) ? OPEN_CYC : CLOSE_CYC;
  localparam int TMAX   = (TMAX_A > TIMEOUT) ? TMAX_A : TIMEOUT;
  localparam int TMR_W  = $clog2(TMAX + 1);

  arb_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  lane_t            lane_q, lane_d;
  lane_t            last_q, last_d;
  logic             seen_q, seen_d;
  logic             counted_q, counted_d;
  tal_t             tal_q;
  logic             gnt_in_q, gnt_out_q;
  logic             inc, dec;
  logic             elig_in, elig_out;
  logic [OCC_W-1:0] occ;
  logic             full, empty;
  lane_t            pick;

  assign elig_in  = bus.REQ_IN  & ~full;
  assign elig_out = bus.REQ_OUT & ~empty;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lane_d    = lane_q;
    last_d    = last_q;
    seen_d    = seen_q;
    counted_d = counted_q;
    inc       = 1'b0;
    dec       = 1'b0;
    pick      = (elig_in && elig_out) ? ((last_q == LANE_IN) ? LANE_OUT : LANE_IN)
                                      : (elig_in ? LANE_IN : LANE_OUT);
    case (state_q)
      IDLE: begin
        if (elig_in || elig_out) begin
          lane_d  = pick;
          last_d  = pick;
          timer_d = '0;
          state_d = OPENING;
        end
      end
      OPENING: begin
        if (timer_q == TMR_W'(OPEN_CYC - 1)) begin
          timer_d = '0;
          state_d = OPEN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OPEN: begin
        if (bus.C) seen_d = 1'b1;
        if (seen_q && !bus.C) begin
          // Only the first completed passage of a grant moves occupancy.
          timer_d = '0;
          state_d = CLOSING;
          if (!counted_q) begin
            counted_d = 1'b1;
            inc       = (lane_q == LANE_IN);
            dec       = (lane_q == LANE_OUT);
          end
        end else if (!seen_q) begin
          if (!bus.C && timer_q == TMR_W'(TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = CLOSING;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      CLOSING: begin
        if (bus.C) begin
          timer_d = '0;
          state_d = OPENING;
        end else if (timer_q == TMR_W'(CLOSE_CYC - 1)) begin
          timer_d   = '0;
          seen_d    = 1'b0;
          counted_d = 1'b0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      lane_q    <= LANE_IN;
      last_q    <= LANE_OUT;
      seen_q    <= 1'b0;
      counted_q <= 1'b0;
      tal_q     <= DOWN;
      gnt_in_q  <= 1'b0;
      gnt_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lane_q    <= lane_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      counted_q <= counted_d;
      tal_q     <= tal_of(state_d);
      gnt_in_q  <= (state_d != IDLE) && (lane_d == LANE_IN);
      gnt_out_q <= (state_d != IDLE) && (lane_d == LANE_OUT);
    end
  end

  occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk     (clk),
    .rst     (R),
    .inc_i   (inc),
    .dec_i   (dec),
    .occ_o   (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.TAL     = tal_q;
  assign bus.GNT_IN  = gnt_in_q;
  assign bus.GNT_OUT = gnt_out_q;
  assign bus.OCC     = occ;
  assign bus.FULL    = full;
  assign bus.EMPTY   = empty;

endmodule
